// File: rtl/countdown_pkg.sv
// Shared types and defaults for the countdown timer block.
// Optional pause support is selected by the COUNTDOWN_PAUSE_EN macro (see countdown_timer).
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH          = 6;
    localparam int DEFAULT_TICKS_PER_UNIT = 4;

    // Divider counter width; at least one bit so TICKS_PER_UNIT=1 still elaborates.
    function automatic int div_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/countdown_timer_tick_divider.sv
// Timebase divider: counts qualified ticks and flags the tick that completes one unit.
module tick_divider
    import countdown_pkg::*;
#(
    parameter int TICKS_PER_UNIT = DEFAULT_TICKS_PER_UNIT
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear,
    input  logic enable,
    input  logic tick,
    output logic unit
);

    localparam int            CW   = div_width(TICKS_PER_UNIT);
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_UNIT - 1);

    logic [CW-1:0] cnt;

    // Combinational so the parent can decrement on the same edge that samples the tick.
    assign unit = enable & tick & (cnt == LAST);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && tick) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: loads a value, decrements once per TICKS_PER_UNIT ticks, flags expiry.
// Define COUNTDOWN_PAUSE_EN to compile in pause_i support; otherwise pause_i is ignored.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int TICKS_PER_UNIT = DEFAULT_TICKS_PER_UNIT,
    parameter int WIDTH          = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             tick_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             pause_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] q_o,
    output logic             running_o,
    output logic             expired_o,
    output logic             done_o,
    output logic [1:0]       state_o
);

    state_t           state, state_n;
    logic [WIDTH-1:0] q_n;
    logic             running_n, expired_n, done_n;
    logic             pause_eff;
    logic             div_clear, div_enable, unit;

`ifdef COUNTDOWN_PAUSE_EN
    assign pause_eff = pause_i;
`else
    assign pause_eff = 1'b0 & pause_i;
`endif

    // All outputs are registered and meaningful every cycle; there is no handshake.
    assign div_clear  = start_i | (state == ST_RUN && stop_i);
    assign div_enable = (state == ST_RUN) & ~start_i & ~stop_i & ~pause_eff;

    tick_divider #(
        .TICKS_PER_UNIT(TICKS_PER_UNIT)
    ) u_div (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear  (div_clear),
        .enable (div_enable),
        .tick   (tick_i),
        .unit   (unit)
    );

    always_comb begin
        state_n = state;
        q_n     = q_o;
        done_n  = 1'b0;
        if (start_i) begin
            q_n = load_val_i;
            if (load_val_i == '0) begin
                state_n = ST_EXPIRED;
                done_n  = 1'b1;
            end else begin
                state_n = ST_RUN;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (stop_i) begin
                        state_n = ST_IDLE;
                    end else if (unit && q_o != '0) begin
                        q_n = q_o - WIDTH'(1);
                        if (q_o == WIDTH'(1)) begin
                            state_n = ST_EXPIRED;
                            done_n  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        running_n = (state_n == ST_RUN) & ~(pause_eff & ~start_i);
        expired_n = (state_n == ST_EXPIRED);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state     <= ST_IDLE;
            q_o       <= '0;
            running_o <= 1'b0;
            expired_o <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            state     <= state_n;
            q_o       <= q_n;
            running_o <= running_n;
            expired_o <= expired_n;
            done_o    <= done_n;
        end
    end

    assign state_o = state;

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter TICKS_PER_UNIT, default 4, number of tick_i pulses per count decrement (≥1).
REQ-002 SHALL have parameter WIDTH, default 6, width of count value.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_i  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port tick_i  input  1  one-cycle timebase enable pulse.
REQ-006 SHALL have port start_i  input  1  load load_val_i and begin countdown.
REQ-007 SHALL have port stop_i  input  1  abort countdown, hold current count.
REQ-008 SHALL have port pause_i  input  1  freeze countdown (effective only per REQ-027).
REQ-009 SHALL have port load_val_i  input  WIDTH  countdown start value.
REQ-010 SHALL have port q_o  output  WIDTH  remaining count.
REQ-011 SHALL have port running_o  output  1  high in RUN and not paused.
REQ-012 SHALL have port expired_o  output  1  level, high in EXPIRED.
REQ-013 SHALL have port done_o  output  1  one-cycle pulse on entry to EXPIRED.

Function
REQ-014 SHALL implement states IDLE, RUN, EXPIRED; all outputs registered.
REQ-015 start_i in any state SHALL, next edge, load q_o=load_val_i, clear divider, enter RUN; load_val_i=0 SHALL enter EXPIRED directly with done_o pulse.
REQ-016 start_i SHALL take priority over stop_i, pause_i and tick_i in the same cycle.
REQ-017 In RUN, each tick_i SHALL increment the divider; tick_i with divider=TICKS_PER_UNIT-1 SHALL clear divider and decrement q_o by 1.
REQ-018 Decrement from q_o=1 SHALL set q_o=0, enter EXPIRED, assert done_o for exactly one cycle on that same edge.
REQ-019 q_o SHALL never wrap below 0 nor change in IDLE or EXPIRED.
REQ-020 stop_i in RUN (no start_i) SHALL enter IDLE next edge, hold q_o, clear divider, no done_o.
REQ-021 tick_i SHALL be ignored in IDLE and EXPIRED; stop_i ignored in IDLE and EXPIRED.
REQ-022 expired_o SHALL remain high until start_i or reset.
REQ-023 Decrement latency: q_o SHALL update on the edge sampling the qualifying tick_i (1 cycle).

Reset
REQ-024 reset_i low at a rising edge SHALL force IDLE, q_o=0, divider=0, running_o=0, expired_o=0, done_o=0.
REQ-025 Reset SHALL override all other inputs, including mid-countdown and the cycle of expiry.

Configuration
REQ-026 Macro COUNTDOWN_PAUSE_EN SHALL compile pause support in or out.
REQ-027 With COUNTDOWN_PAUSE_EN defined: pause_i high in RUN SHALL freeze divider and q_o, keep state RUN, drive running_o=0; release resumes with divider value preserved.
REQ-028 Without COUNTDOWN_PAUSE_EN: pause_i port SHALL exist but be ignored; running_o SHALL equal (state==RUN).

Structure
REQ-029 Package countdown_pkg SHALL hold state enum type and default WIDTH/TICKS_PER_UNIT constants.
REQ-030 Sub-module tick_divider SHALL implement the divider (inputs clk_i, reset_i, clear, enable, tick; output unit pulse).

Verification
REQ-031 load_val_i=3, start_i, 12 ticks (TICKS_PER_UNIT=4) -> q_o 3,2,1,0 on ticks 4/8/12; done_o one cycle at tick 12; expired_o held.
REQ-032 start_i with load_val_i=0 -> next edge EXPIRED, expired_o=1, done_o one cycle, q_o=0.
REQ-033 load 5, 6 ticks, stop_i -> IDLE, q_o=4 held; further ticks no change; start_i load 2 -> RUN, q_o=2.
REQ-034 start_i and stop_i and tick_i same cycle in RUN -> reload wins, divider=0, state RUN.
REQ-035 reset_i low on same edge as final tick of count 1 -> q_o=0, IDLE, done_o=0, expired_o=0.
REQ-036 With COUNTDOWN_PAUSE_EN: load 2, 2 ticks, pause_i high for 8 ticks, release, 2 ticks -> q_o=1, running_o=0 during pause; without macro same stimulus -> q_o=0, EXPIRED.
